// File: rtl/adder_tree_stage_gated.sv
// adder_tree_stage_gated: pipelined, operand-gated signed adder tree.
// Sums N_IN sign-extended IN_W-bit lanes through a registered pairwise tree.
// A level's registers load only when the level below holds valid data, so
// idle cycles leave the datapath still. The output reads zero when not valid.
// Optional feature macro: ADDER_ACCUM_EN. When defined, ACC_LEN consecutive
// tree results are summed before one output pulse is emitted.
module adder_tree_stage_gated #(
  parameter int N_IN    = 3,
  parameter int IN_W    = 15,
  parameter int ACC_LEN = 4,
  localparam int LVL    = $clog2(N_IN),
  localparam int TREE_W = IN_W + LVL,
  localparam int ACC_W  = $clog2(ACC_LEN),
`ifdef ADDER_ACCUM_EN
  localparam bit ACC_EN = 1'b1,
`else
  localparam bit ACC_EN = 1'b0,
`endif
  localparam int OUT_W  = TREE_W + (ACC_EN ? ACC_W : 0)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   busy
);

  // Valid shadow bits: v_s[0] is the input qualifier, v_s[k] marks tree level k.
  logic [LVL:1] valid_q;
  logic [LVL:0] v_s;
  assign v_s = {valid_q, in_valid};

  logic signed [TREE_W-1:0] tree_result_s;
  logic                     out_valid_d, out_valid_q;
  logic [OUT_W-1:0]         out_sum_d, out_sum_q;

  // Level 0 is the raw lane set; level k holds ceil(N_IN / 2^k) terms of IN_W+k bits.
  for (genvar k = 0; k <= LVL; k++) begin : g_lvl
    localparam int CNT = (N_IN + (2 ** k) - 1) / (2 ** k);
    localparam int W   = IN_W + k;
    logic signed [W-1:0] term [CNT];

    if (k == 0) begin : g_in
      for (genvar j = 0; j < CNT; j++) begin : g_lane
        assign term[j] = in_data[j*IN_W +: IN_W];
      end
    end else begin : g_add
      localparam int PCNT = (N_IN + (2 ** (k-1)) - 1) / (2 ** (k-1));
      logic signed [W-1:0] nxt_s [CNT];

      for (genvar j = 0; j < CNT; j++) begin : g_node
        if (2*j + 1 < PCNT) begin : g_pair
          assign nxt_s[j] = {g_lvl[k-1].term[2*j][W-2],   g_lvl[k-1].term[2*j]}
                          + {g_lvl[k-1].term[2*j+1][W-2], g_lvl[k-1].term[2*j+1]};
        end else begin : g_pass
          // Odd leftover: widened and registered so every path has equal latency.
          assign nxt_s[j] = {g_lvl[k-1].term[2*j][W-2], g_lvl[k-1].term[2*j]};
        end
      end

      // Level-k terms: load only behind valid data from the level below, else hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < CNT; j++) begin
            term[j] <= '0;
          end
        end else if (!clr && v_s[k-1]) begin
          term <= nxt_s;
        end
      end
    end
  end

  assign tree_result_s = g_lvl[LVL].term[0];

  // Valid shadow pipeline: shifts every cycle and is flushed by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else begin
      valid_q <= v_s[LVL-1:0];
    end
  end

`ifdef ADDER_ACCUM_EN
  logic signed [OUT_W-1:0] acc_d, acc_q;
  logic        [ACC_W-1:0] cnt_d, cnt_q;
  logic signed [OUT_W-1:0] tree_ext_s;

  assign tree_ext_s = {{ACC_W{tree_result_s[TREE_W-1]}}, tree_result_s};

  // Accumulate tree results; the ACC_LEN-th result emits acc+result and restarts.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_sum_d   = '0;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (v_s[LVL]) begin
      if (cnt_q == ACC_W'(ACC_LEN - 1)) begin
        out_sum_d   = acc_q + tree_ext_s;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_q + tree_ext_s;
        cnt_d = cnt_q + ACC_W'(1);
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Accumulator and result counter state; partial sums survive input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (|valid_q) | (cnt_q != '0);
`else
  // Direct mode: every tree result leaves as its own output pulse.
  always_comb begin
    out_valid_d = 1'b0;
    out_sum_d   = '0;
    if (!clr && v_s[LVL]) begin
      out_valid_d = 1'b1;
      out_sum_d   = tree_result_s;
    end else begin
      out_valid_d = 1'b0;
      out_sum_d   = '0;
    end
  end

  assign busy = |valid_q;
`endif

  // Registered output stage; the sum reads zero whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_adder_tree_stage_gated.sv
// Scoreboard bench for adder_tree_stage_gated: a driver pushes expected sums
// (with the cycle they must appear) and a negedge monitor pops and compares.
module tb_adder_tree_stage_gated;
  localparam int N_IN    = 3;
  localparam int IN_W    = 15;
  localparam int ACC_LEN = 4;
  localparam int LVL     = $clog2(N_IN);
`ifdef ADDER_ACCUM_EN
  localparam int OUT_W   = IN_W + LVL + $clog2(ACC_LEN);
`else
  localparam int OUT_W   = IN_W + LVL;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic                 in_valid = 1'b0;
  logic [N_IN*IN_W-1:0] in_data = '0;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_sum;
  logic                 busy;

  typedef struct {
    int sum;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_sum = 0;
  int   acc_cnt = 0;
  int   last_tree = 0;
  bit   mon_en = 1'b0;
  bit   mon_busy;

  adder_tree_stage_gated #(.N_IN(N_IN), .IN_W(IN_W), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_sum(out_sum), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain signed sum of the lanes.
  function automatic int set_sum(input logic [N_IN*IN_W-1:0] d);
    int s;
    logic signed [IN_W-1:0] l;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      l = d[i*IN_W +: IN_W];
      s += int'(l);
    end
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_flush();
    sbq.delete();
    acc_sum = 0;
    acc_cnt = 0;
  endtask

  // Drive one cycle of input at posedge+1 and record the expected response.
  task automatic drive(input logic v, input logic [N_IN*IN_W-1:0] d);
    exp_t e;
    int   s;
    in_valid = v;
    in_data  = d;
    if (v) begin
      s = set_sum(d);
      last_tree = s;
`ifdef ADDER_ACCUM_EN
      acc_sum += s;
      acc_cnt++;
      if (acc_cnt == ACC_LEN) begin
        e.sum = acc_sum;
        e.cyc = cyc + 1 + LVL;
        sbq.push_back(e);
        acc_sum = 0;
        acc_cnt = 0;
      end
`else
      e.sum = s;
      e.cyc = cyc + 1 + LVL;
      sbq.push_back(e);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_IN*IN_W-1:0] pack3(input int a, input int b, input int c);
    logic [N_IN*IN_W-1:0] d;
    logic [IN_W-1:0] la, lb, lc;
    la = IN_W'(a);
    lb = IN_W'(b);
    lc = IN_W'(c);
    d = {lc, lb, la};
    return d;
  endfunction

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("out_sum", int'($signed(out_sum)), mon_e.sum);
          check("latency", cyc, mon_e.cyc);
        end
      end else begin
        check("out_sum_idle_zero", out_sum, 0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          mon_e = sbq.pop_front();
          check("missing_out_valid", 0, 1);
        end
      end
`ifndef ADDER_ACCUM_EN
      mon_busy = 1'b0;
      foreach (sbq[i]) begin
        if (sbq[i].cyc - LVL <= cyc && cyc < sbq[i].cyc) mon_busy = 1'b1;
      end
      check("busy", busy, mon_busy);
`endif
    end
  end

  initial begin
    logic [N_IN*IN_W-1:0] d;
    logic [IN_W-1:0] lane;
    int mode;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(1'b0, '0);

    // Lanes {1,2,3}, then the sign-extension / odd pass-through case
    drive(1'b1, pack3(1, 2, 3));
    repeat (4) drive(1'b0, '0);
    drive(1'b1, pack3(32'h7FFF, 32'h4000, 32'h4000));
    repeat (4) drive(1'b0, '0);

    // Back-to-back stream of 8 sets
    for (int i = 0; i < 8; i++) drive(1'b1, pack3(i, 0, 0));
    repeat (4) drive(1'b0, '0);

    // Randomized traffic including extreme lane values
    for (int n = 0; n < 300; n++) begin
      mode = int'($urandom_range(0, 5));
      for (int i = 0; i < N_IN; i++) begin
        case (mode)
          0:       lane = {1'b1, {(IN_W-1){1'b0}}};
          1:       lane = {1'b0, {(IN_W-1){1'b1}}};
          default: lane = IN_W'($urandom);
        endcase
        d[i*IN_W +: IN_W] = lane;
      end
      drive(($urandom_range(0, 3) != 0), d);
    end

    // Idle window: nothing emitted, tree registers hold the last result
    repeat (20) drive(1'b0, '0);
    check("idle_busy", busy, (acc_cnt != 0));
    check("idle_out_valid", out_valid, 0);
    check("gated_tree_hold", int'($signed(dut.tree_result_s)), last_tree);

    // clr flush: in-flight set is discarded, same-cycle in_valid ignored
    drive(1'b1, pack3(5, 6, 7));
    in_valid = 1'b1;
    in_data  = pack3(9, 9, 9);
    clr = 1'b1;
    @(posedge clk);
    model_flush();
    #1;
    clr = 1'b0;
    repeat (5) drive(1'b0, '0);
    check("clr_busy", busy, 0);

    // Async reset flush of an in-flight set
    drive(1'b1, pack3(11, 12, 13));
    rst_n = 1'b0;
    model_flush();
    #1;
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) drive(1'b0, '0);

`ifdef ADDER_ACCUM_EN
    // Four {1,1,1} sets with a 3-cycle gap after the second -> one pulse of 12
    drive(1'b1, pack3(1, 1, 1));
    drive(1'b1, pack3(1, 1, 1));
    repeat (3) drive(1'b0, '0);
    check("accum_partial_busy", busy, 1);
    drive(1'b1, pack3(1, 1, 1));
    drive(1'b1, pack3(1, 1, 1));
    check("accum_expected_12", (sbq.size() > 0) ? sbq[sbq.size()-1].sum : -1, 12);
    repeat (5) drive(1'b0, '0);
`else
    // Post-reset sanity: fresh result after flushes
    drive(1'b1, pack3(-1, -2, 4));
    repeat (4) drive(1'b0, '0);
`endif

    // Bounded drain: anything left in the scoreboard was never emitted
    repeat (LVL + 3) drive(1'b0, '0);
    check("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
